digit_scan_driver: RTL and testbench

Parameterised, self-timed multiplexing driver for common-anode 7-segment displays with any digit count. It generalises the stopwatch's fixed 4-digit anode selector and adds these functions:
- internal refresh prescaler
- per-frame input snapshot (no tearing)
- hex decode with decimal points
- leading-zero suppression and per-digit blanking
- PWM brightness with anti-ghosting dead time

It sits between the stopwatch counter/BCD logic and the board's anode/segment pins.

---
 rtl/digit_scan_if.sv | 31 +++
 rtl/digit_scan_driver.sv | 146 ++++++++++++++
 tb/tb_digit_scan_driver.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/digit_scan_if.sv
// Bundle between the stopwatch display logic (master) and the multiplexed
// 7-segment scan driver (slave).
interface digit_scan_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BRIGHT_W   = 3
);
  localparam int IDX_W = $clog2(NUM_DIGITS);

  logic                    en;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_suppress;
  logic [BRIGHT_W-1:0]     brightness;

  logic [NUM_DIGITS-1:0]   anode;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_tick;

  modport master (
    output en, digits, dp_in, blank_mask, lz_suppress, brightness,
    input  anode, seg, dp, digit_idx, frame_tick
  );

  modport slave (
    input  en, digits, dp_in, blank_mask, lz_suppress, brightness,
    output anode, seg, dp, digit_idx, frame_tick
  );
endinterface

// File: rtl/digit_scan_driver.sv
// Self-timed multiplexing driver for common-anode 7-segment displays:
// prescaled digit scan, per-frame snapshot, hex decode, LZ blanking, PWM.
module digit_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BRIGHT_W    = 3,
  parameter int DEAD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  digit_scan_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int LIM_W = PRE_W + BRIGHT_W + 2;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [LIM_W-1:0] DIV_EXT  = LIM_W'(REFRESH_DIV);
  localparam logic [LIM_W-1:0] DEAD_EXT = LIM_W'(DEAD_CYCLES);

  logic [PRE_W-1:0]        prescaler;
  logic [IDX_W-1:0]        digit_idx_q;
  logic                    slot_end;
  logic                    frame_wrap;

  logic [4*NUM_DIGITS-1:0] snap_digits;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;
  logic                    snap_lz;

  logic [LIM_W-1:0]        on_limit;
  logic [LIM_W-1:0]        pre_ext;
  logic                    slot_active;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   visible;
  logic [3:0]              cur_nib;

  logic [NUM_DIGITS-1:0]   anode_d;
  logic [6:0]              seg_d;
  logic                    dp_d;

  logic [NUM_DIGITS-1:0]   anode_q;
  logic [6:0]              seg_q;
  logic                    dp_q;
  logic                    tick_q;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    hex7 = 7'h7F;
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      4'hF: hex7 = 7'b0001110;
    endcase
  endfunction

  assign slot_end   = (prescaler == PRE_LAST);
  assign frame_wrap = bus.en && slot_end && (digit_idx_q == IDX_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler   <= '0;
      digit_idx_q <= '0;
    end else if (bus.en) begin
      if (slot_end) begin
        prescaler   <= '0;
        digit_idx_q <= (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
      end else begin
        prescaler <= prescaler + PRE_W'(1);
      end
    end
  end

  // Tracking inputs while disabled means resuming never shows stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_digits <= '0;
      snap_dp     <= '0;
      snap_blank  <= '0;
      snap_lz     <= 1'b0;
    end else if (frame_wrap || !bus.en) begin
      snap_digits <= bus.digits;
      snap_dp     <= bus.dp_in;
      snap_blank  <= bus.blank_mask;
      snap_lz     <= bus.lz_suppress;
    end
  end

  always_comb begin
    on_limit    = ((LIM_W'(bus.brightness) + LIM_W'(1)) * DIV_EXT) >> BRIGHT_W;
    pre_ext     = LIM_W'(prescaler);
    slot_active = (pre_ext >= DEAD_EXT) && (pre_ext < on_limit);

    // zero_run stays set while every nibble from the top down to i is zero.
    zero_run = 1'b1;
    visible  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run   = zero_run && (snap_digits[4*i +: 4] == 4'h0);
      visible[i] = !snap_blank[i] && !(snap_lz && (i != 0) && zero_run);
    end

    cur_nib = snap_digits[{digit_idx_q, 2'b00} +: 4];

    anode_d = '1;
    if (bus.en && slot_active && visible[digit_idx_q]) begin
      anode_d[digit_idx_q] = 1'b0;
    end
    seg_d = hex7(cur_nib);
    dp_d  = ~snap_dp[digit_idx_q];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode_q <= '1;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      tick_q  <= frame_wrap;
    end
  end

  assign bus.anode      = anode_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.digit_idx  = digit_idx_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_digit_scan_driver.sv
// Self-checking bench for digit_scan_driver: frame-position reference model,
// directed scenarios with literal expectations, then randomized stimulus.
module tb_digit_scan_driver;

  localparam int NUM_DIGITS = 4;
  localparam int DIV        = 8;
  localparam int BW         = 3;
  localparam int DEAD       = 1;
  localparam int FRAME      = NUM_DIGITS * DIV;

  logic clk;
  logic rst_n;

  digit_scan_if #(.NUM_DIGITS(NUM_DIGITS), .BRIGHT_W(BW)) bus_if ();

  digit_scan_driver #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(DIV),
    .BRIGHT_W   (BW),
    .DEAD_CYCLES(DEAD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Reference model: position within the frame plus the latched frame data.
  int         m_pos = 0;
  logic [15:0] m_dig;
  logic [3:0] m_dp;
  logic [3:0] m_blank;
  logic       m_lz;
  bit         model_valid = 0;
  logic [3:0] exp_anode;
  logic [6:0] exp_seg;
  logic       exp_dp;
  logic [1:0] exp_idx;
  logic       exp_tick;

  always @(posedge clk) begin
    int  k;
    int  p;
    int  lim;
    bit  vis;
    bit  wrap;
    if (!rst_n) begin
      m_pos       = 0;
      m_dig       = '0;
      m_dp        = '0;
      m_blank     = '0;
      m_lz        = 1'b0;
      exp_anode   = 4'hF;
      exp_seg     = 7'h7F;
      exp_dp      = 1'b1;
      exp_tick    = 1'b0;
      model_valid = 1;
    end else begin
      k   = m_pos / DIV;
      p   = m_pos % DIV;
      lim = ((int'(bus_if.brightness) + 1) * DIV) >> BW;
      vis = (m_blank[k] == 1'b0) && !(m_lz && k != 0 && (m_dig >> (4*k)) == 16'h0);
      exp_anode = 4'hF;
      if (bus_if.en && p >= DEAD && p < lim && vis) exp_anode[k] = 1'b0;
      exp_seg  = seg_tab[m_dig[4*k +: 4]];
      exp_dp   = ~m_dp[k];
      wrap     = bus_if.en && (m_pos == FRAME - 1);
      exp_tick = wrap;
      if (bus_if.en) m_pos = (m_pos + 1) % FRAME;
      if (wrap || !bus_if.en) begin
        m_dig   = bus_if.digits;
        m_dp    = bus_if.dp_in;
        m_blank = bus_if.blank_mask;
        m_lz    = bus_if.lz_suppress;
      end
    end
    exp_idx = 2'(m_pos / DIV);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      checkOutput("model anode",      32'(bus_if.anode),      32'(exp_anode));
      checkOutput("model seg",        32'(bus_if.seg),        32'(exp_seg));
      checkOutput("model dp",         32'(bus_if.dp),         32'(exp_dp));
      checkOutput("model digit_idx",  32'(bus_if.digit_idx),  32'(exp_idx));
      checkOutput("model frame_tick", 32'(bus_if.frame_tick), 32'(exp_tick));
    end
  end

  task automatic applyStimulus(input logic en, input logic [15:0] dig, input logic [3:0] dpv,
                               input logic [3:0] blank, input logic lz, input logic [2:0] bright);
    bus_if.en          = en;
    bus_if.digits      = dig;
    bus_if.dp_in       = dpv;
    bus_if.blank_mask  = blank;
    bus_if.lz_suppress = lz;
    bus_if.brightness  = bright;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitPos(input int target);
    int guard = 0;
    while (m_pos != target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput($sformatf("reach frame position %0d", target), 32'(m_pos), 32'(target));
  endtask

  int low_cnt [4];
  int tick_cnt;
  int dp_cnt;

  task automatic countWindow(input string tag, input int e0, input int e1, input int e2,
                             input int e3, input int etick, input int edp);
    for (int i = 0; i < 4; i++) low_cnt[i] = 0;
    tick_cnt = 0;
    dp_cnt   = 0;
    repeat (FRAME) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) if (!bus_if.anode[i]) low_cnt[i]++;
      if (bus_if.frame_tick) tick_cnt++;
      if (!bus_if.dp) dp_cnt++;
    end
    checkOutput({tag, " lit0"}, 32'(low_cnt[0]), 32'(e0));
    checkOutput({tag, " lit1"}, 32'(low_cnt[1]), 32'(e1));
    checkOutput({tag, " lit2"}, 32'(low_cnt[2]), 32'(e2));
    checkOutput({tag, " lit3"}, 32'(low_cnt[3]), 32'(e3));
    checkOutput({tag, " ticks"}, 32'(tick_cnt), 32'(etick));
    checkOutput({tag, " dp lows"}, 32'(dp_cnt), 32'(edp));
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0000, 4'h0, 4'h0, 1'b0, 3'd0);
    waitCycles(3);
    checkOutput("reset anode", 32'(bus_if.anode), 32'hF);
    checkOutput("reset seg", 32'(bus_if.seg), 32'h7F);
    checkOutput("reset dp", 32'(bus_if.dp), 32'h1);
    checkOutput("reset idx", 32'(bus_if.digit_idx), 32'h0);
    checkOutput("reset tick", 32'(bus_if.frame_tick), 32'h0);

    // Basic scan of 1234 at full brightness.
    rst_n = 1'b1;
    applyStimulus(1'b0, 16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    waitCycles(2);
    bus_if.en = 1'b1;
    waitCycles(1);
    checkOutput("slot0 idx", 32'(bus_if.digit_idx), 32'h0);
    checkOutput("slot0 seg", 32'(bus_if.seg), 32'(7'b0011001));
    checkOutput("slot0 dead anode", 32'(bus_if.anode), 32'hF);
    waitCycles(8);
    checkOutput("slot1 idx", 32'(bus_if.digit_idx), 32'h1);
    checkOutput("slot1 seg", 32'(bus_if.seg), 32'(7'b0110000));
    checkOutput("slot1 dead anode", 32'(bus_if.anode), 32'hF);
    waitCycles(1);
    checkOutput("slot1 anode", 32'(bus_if.anode), 32'(4'b1101));
    countWindow("bright7", 7, 7, 7, 7, 1, 0);

    bus_if.brightness = 3'd3;
    waitCycles(2);
    countWindow("bright3", 3, 3, 3, 3, 1, 0);
    bus_if.brightness = 3'd0;
    waitCycles(2);
    countWindow("bright0", 0, 0, 0, 0, 1, 0);

    // Leading-zero suppression.
    applyStimulus(1'b1, 16'h0070, 4'h0, 4'h0, 1'b1, 3'd7);
    waitCycles(40);
    countWindow("lz0070", 7, 7, 0, 0, 1, 0);
    bus_if.digits = 16'h0000;
    waitCycles(40);
    countWindow("lz0000", 7, 0, 0, 0, 1, 0);

    // Mid-frame data change shows only at the next frame.
    applyStimulus(1'b1, 16'h1234, 4'h0, 4'h0, 1'b0, 3'd7);
    waitCycles(40);
    waitPos(8);
    bus_if.digits = 16'h5678;
    waitCycles(9);
    checkOutput("old frame seg", 32'(bus_if.seg), 32'(7'b0100100));
    waitPos(1);
    checkOutput("new frame seg", 32'(bus_if.seg), 32'(7'b0000000));

    applyStimulus(1'b1, 16'h5678, 4'b0010, 4'b0100, 1'b0, 3'd7);
    waitCycles(40);
    countWindow("blank2 dp1", 7, 7, 0, 7, 1, 8);

    // Scan freeze mid-slot on digit 2.
    applyStimulus(1'b1, 16'h5678, 4'h0, 4'h0, 1'b0, 3'd7);
    waitCycles(40);
    waitPos(19);
    bus_if.en = 1'b0;
    waitCycles(1);
    checkOutput("freeze anode", 32'(bus_if.anode), 32'hF);
    checkOutput("freeze idx", 32'(bus_if.digit_idx), 32'h2);
    waitCycles(4);
    checkOutput("held idx", 32'(bus_if.digit_idx), 32'h2);
    bus_if.en = 1'b1;
    waitCycles(1);
    checkOutput("resume anode", 32'(bus_if.anode), 32'(4'b1011));
    checkOutput("resume idx", 32'(bus_if.digit_idx), 32'h2);

    // Reset in the middle of digit 3.
    waitPos(29);
    rst_n = 1'b0;
    waitCycles(1);
    checkOutput("midreset anode", 32'(bus_if.anode), 32'hF);
    checkOutput("midreset seg", 32'(bus_if.seg), 32'h7F);
    checkOutput("midreset dp", 32'(bus_if.dp), 32'h1);
    checkOutput("midreset idx", 32'(bus_if.digit_idx), 32'h0);
    checkOutput("midreset tick", 32'(bus_if.frame_tick), 32'h0);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    repeat (1200) begin
      @(negedge clk);
      rst_n     = ($urandom_range(0, 99) != 0);
      bus_if.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 15) == 0) bus_if.digits = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bus_if.digits[15:8] = 8'h00;
      if ($urandom_range(0, 7) == 0) bus_if.brightness = 3'($urandom);
      if ($urandom_range(0, 19) == 0) bus_if.lz_suppress = 1'($urandom);
      if ($urandom_range(0, 19) == 0) bus_if.blank_mask = 4'($urandom);
      if ($urandom_range(0, 19) == 0) bus_if.dp_in = 4'($urandom);
    end
    rst_n = 1'b1;
    waitCycles(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
